// File: rtl/encoder_4x2_reg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_4x2_reg
//  Description : Registered 4-to-2 priority encoder with a one-deep
//                valid/ready output stage, a not-one-hot error flag and a
//                saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_4x2_reg #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [1:0]       enc_idx;
  logic             enc_err;

  // The stage can take a word when empty, or when the held word leaves this cycle.
  assign in_ready  = (state == EMPTY) | out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid & in_ready;

  // Priority encode on the highest set bit; flag anything that is not exactly one-hot.
  always_comb begin
    enc_idx = 2'b00;
    if (in[3])      enc_idx = 2'b11;
    else if (in[2]) enc_idx = 2'b10;
    else if (in[1]) enc_idx = 2'b01;
    else            enc_idx = 2'b00;
    // A non-zero word with a single bit clears to zero when ANDed with itself minus one.
    enc_err = (in == 4'b0000) | ((in & (in - 4'd1)) != 4'b0000);
  end

  // Next-state logic: fill on accept, drain on consume without a replacing accept.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Output word register: loads only on accept, otherwise holds (also while empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= 2'b00;
      out_err <= 1'b0;
    end else if (accept) begin
      out     <= enc_idx;
      out_err <= enc_err;
    end
  end

  // Saturating count of accepted words that were not one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       err_count <= '0;
    else if (accept && enc_err && err_count != CNT_MAX) err_count <= err_count + 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/encoder_4x2_reg.md
ENCODER_4X2_REG -- requirements
Module: encoder_4x2_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the error counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port in, input, 4, the one-hot code word to encode.
REQ-005 The block SHALL have port in_valid, input, 1, which qualifies in.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have port out, output, 2, the registered binary index.
REQ-008 The block SHALL have port out_err, output, 1, which flags that the word held in out was not one-hot.
REQ-009 The block SHALL have port out_valid, output, 1, which qualifies out and out_err.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 The block SHALL have port err_count, output, CNT_W, a saturating count of non-one-hot words accepted.

Function
REQ-012 The block SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 The block SHALL drive in_ready = (state==EMPTY) | out_ready, combinationally, with no dependence on in_valid.
REQ-014 The block SHALL accept a word exactly when in_valid & in_ready is high at a rising clk edge.
REQ-015 On accept, out SHALL load the index of the highest set bit of in: 1xxx->11, 01xx->10, 001x->01, 0001->00, 0000->00.
REQ-016 On accept, out_err SHALL load 1 if in is not exactly one-hot (zero bits or two or more bits set), and 0 otherwise.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears with out_valid=1 after edge N.
REQ-018 Transition EMPTY->FULL SHALL occur on accept; FULL->EMPTY SHALL occur on out_ready with no accept; FULL SHALL remain FULL on a simultaneous consume and accept, and the new word replaces the old word.
REQ-019 The block SHALL sustain one word per cycle when out_ready is held high.
REQ-020 While out_valid=1 and out_ready=0, out, out_err and out_valid SHALL hold stable, and in_ready SHALL be 0.
REQ-021 In EMPTY, out and out_err SHALL retain their last values, and consumers SHALL ignore them.
REQ-022 err_count SHALL increment by 1 on each accepted word with out_err-condition true, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 err_count SHALL NOT change on non-accepted cycles or on consume-only cycles.

Reset
REQ-024 While rst_n=0, the block SHALL force asynchronously: state=EMPTY, out_valid=0, out=00, out_err=0, err_count=0; in_ready then equals 1.
REQ-025 Reset asserted mid-operation SHALL discard any held word; no accept SHALL occur on the edge where rst_n is low.
REQ-026 The first accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 The bench SHALL cover: in=0001, in_valid=1, out_ready=1 -> after one edge out=00, out_err=0, out_valid=1, err_count=0.
REQ-028 The bench SHALL cover: back-to-back 0010, 0100, 1000 with out_ready=1 -> out=01, 10, 11 on consecutive cycles, out_valid continuously 1.
REQ-029 The bench SHALL cover: in=0110, then in=0000 -> out=10/out_err=1, then out=00/out_err=1, with err_count=2.
REQ-030 The bench SHALL cover: hold word 0100 with out_ready=0 and present 0001 -> in_ready=0, out stays 10 for all stall cycles; raise out_ready -> 0001 accepted, out=00 the next cycle.
REQ-031 The bench SHALL cover: 20 accepted words of 1111 with CNT_W=4 -> err_count reaches 15 and remains 15.
REQ-032 The bench SHALL cover: drop rst_n asynchronously between edges while FULL with err_count=3 -> out_valid=0, out=00, out_err=0, err_count=0 immediately, without waiting for a clk edge.
